// File: rtl/demux_1x2_stream_nbits.sv
// 1-to-2 valid/ready stream demux with a one-entry registered output stage.
// Define DEMUX_SEL_LOCK_EN to lock the destination for a whole packet (in_last-delimited).
module demux_1x2_stream_nbits #(
   parameter int unsigned bits = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sel,
   input  logic [bits-1:0] xin,
   input  logic            in_valid,
   input  logic            in_last,
   output logic            in_ready,
   output logic [bits-1:0] xout_0,
   output logic [bits-1:0] xout_1,
   output logic            out_valid_0,
   output logic            out_valid_1,
   output logic            out_last_0,
   output logic            out_last_1,
   input  logic            out_ready_0,
   input  logic            out_ready_1
);

   logic            full_q, full_d;
   logic [bits-1:0] data_q, data_d;
   logic            last_q, last_d;
   logic            dest_q, dest_d;
   logic            route_c;
   logic            ready_dest_c;
   logic            pop_c;
   logic            push_c;

   assign ready_dest_c = dest_q ? out_ready_1 : out_ready_0;
   assign pop_c        = full_q && ready_dest_c;
   assign in_ready     = !rst && (!full_q || ready_dest_c);
   assign push_c       = in_valid && in_ready;

`ifdef DEMUX_SEL_LOCK_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PKT  = 1'b1;

   logic [0:0] state_q, state_d;
   logic       lock_sel_q, lock_sel_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   // IDLE follows sel; a multi-beat packet pins the route until its last beat is pushed.
   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      route_c    = sel;
      case (state_q)
         ST_IDLE: begin
            route_c = sel;
            if (push_c && !in_last) begin
               lock_sel_d = sel;
               state_d    = ST_PKT;
            end
         end
         ST_PKT: begin
            route_c = lock_sel_q;
            if (push_c && in_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
`else
   assign route_c = sel;
`endif

   // Push takes priority over pop so a same-cycle pop+push reloads without a bubble.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      last_d = last_q;
      dest_d = dest_q;
      if (push_c) begin
         full_d = 1'b1;
         data_d = xin;
         last_d = in_last;
         dest_d = route_c;
      end else if (pop_c) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
         last_q <= 1'b0;
         dest_q <= 1'b0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         last_q <= last_d;
         dest_q <= dest_d;
      end
   end

   assign out_valid_0 = full_q && !dest_q;
   assign out_valid_1 = full_q && dest_q;
   assign xout_0      = dest_q ? '0 : data_q;
   assign xout_1      = dest_q ? data_q : '0;
   assign out_last_0  = !dest_q && last_q;
   assign out_last_1  = dest_q && last_q;

endmodule
